// File: rtl/pin_uart_rx_if.sv
// Byte-delivery bundle between the UART receiver and its fabric consumer.
// The receiver owns data/valid/status; the consumer owns ready.
interface pin_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/pin_uart_rx.sv
// 8N1 UART receiver for one raw header pin: mid-bit sampling, valid/ready
// delivery, single-cycle framing-error and overrun pulses.
module pin_uart_rx #(
    parameter int F_CLK = 48000000,
    parameter int BAUD  = 115200
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx_pin,
    pin_uart_rx_if.master bus
);
    localparam int CPB   = F_CLK / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB < 4) ? 2 : $clog2(CPB);

    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_CPB_M1  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    if (CPB < 4) begin : g_cpb_check
        $error("pin_uart_rx: F_CLK/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_fill;
    logic             r_armed;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_rxs;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_good;
    logic             w_ferr;
    logic             w_accept;
    logic             w_busy_nxt;

    assign w_rxs      = r_sync2;
    assign w_accept   = r_valid & bus.rx_ready;
    assign w_busy_nxt = (w_state_nxt == ST_START) || (w_state_nxt == ST_DATA) ||
                        (w_state_nxt == ST_STOP);

    // Pin synchronizer and arming; r_fill ensures arming only sees real pin samples, not reset values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= i_rx_pin;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & w_rxs);
        end
    end

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic with start validation, data capture and stop check.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                w_bit_nxt = 3'd0;
                if (r_armed && !w_rxs) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_HALF_M1) begin
                    w_cnt_nxt = CNT_ZERO;
                    w_bit_nxt = 3'd0;
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_CPB_M1) begin
                    w_cnt_nxt              = CNT_ZERO;
                    w_shift_nxt[r_bit_idx] = w_rxs;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_CPB_M1) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_rxs) begin
                        w_good      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    // Registered delivery, handshake and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_ferr <= w_ferr;
            if (w_good && (!r_valid || w_accept)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ovr   <= 1'b0;
            end else if (w_good) begin
                r_ovr <= 1'b1;
            end else begin
                r_ovr <= 1'b0;
                if (w_accept) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.rx_busy   = r_busy;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_pin_uart_rx.sv
// Directed bench for pin_uart_rx at 16 clocks per bit with a byte scoreboard.
module tb_pin_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_pin = 1'b1;
    logic rx_ready = 1'b1;

    pin_uart_rx_if bus();
    assign bus.rx_ready = rx_ready;

    pin_uart_rx #(.F_CLK(16), .BAUD(1)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_rx_pin(rx_pin),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    int cyc = 0;
    logic [7:0] obs_mem [0:63];
    int obs_n = 0;
    int rd = 0;
    logic [7:0] exp_q [$];

    logic prev_valid = 1'b0;
    int n_rise = 0;
    int rise_cyc = 0;
    int n_vcyc = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_busy = 0;
    int fall_cyc = 0;

    // Cycle counter and accepted-byte capture at the handshake edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rx_valid && rx_ready) begin
            obs_mem[obs_n[5:0]] <= bus.rx_data;
            obs_n <= obs_n + 1;
        end
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        prev_valid <= bus.rx_valid;
        if (bus.rx_valid && !prev_valid) begin
            n_rise   <= n_rise + 1;
            rise_cyc <= cyc;
        end
        n_vcyc <= n_vcyc + (bus.rx_valid ? 1 : 0);
        n_ferr <= n_ferr + (bus.frame_err ? 1 : 0);
        n_ovr  <= n_ovr + (bus.overrun ? 1 : 0);
        n_busy <= n_busy + (bus.rx_busy ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [8:0] e;
        logic [8:0] o;
        e = 9'h1FF;
        o = 9'h100;
        if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
        if (rd < obs_n) o = {1'b0, obs_mem[rd[5:0]]};
        rd++;
        chk(tag, {23'd0, o}, {23'd0, e});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts on a negedge; stop_low > 0 holds the stop bit low for that many bit times.
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        rx_pin = 1'b0;
        fall_cyc = cyc;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            cycles(16);
        end
        if (stop_low > 0) begin
            rx_pin = 1'b0;
            cycles(16 * stop_low);
        end
        rx_pin = 1'b1;
        cycles(16);
    endtask

    initial begin
        int b_rise, b_vcyc, b_ferr, b_ovr, b_busy;

        cycles(3);
        chk("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("reset_busy", {31'd0, bus.rx_busy}, 32'd0);
        chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("reset_ovr", {31'd0, bus.overrun}, 32'd0);
        chk("reset_data", {24'd0, bus.rx_data}, 32'd0);
        rst = 1'b0;
        cycles(6);

        // Single byte with ready high.
        b_rise = n_rise; b_vcyc = n_vcyc; b_ferr = n_ferr; b_ovr = n_ovr;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 0);
        cycles(4);
        chk("single_rise_count", n_rise - b_rise, 32'd1);
        chk("single_latency", rise_cyc - fall_cyc, 32'd155);
        chk("single_valid_width", n_vcyc - b_vcyc, 32'd1);
        chk("single_ferr", n_ferr - b_ferr, 32'd0);
        chk("single_ovr", n_ovr - b_ovr, 32'd0);
        sb_check("single_data");

        // Back-to-back frames under backpressure.
        rx_ready = 1'b0;
        b_ferr = n_ferr; b_ovr = n_ovr;
        exp_q.push_back(8'h00);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h3C, 0);
        cycles(4);
        chk("b2b_valid_held", {31'd0, bus.rx_valid}, 32'd1);
        chk("b2b_data_held", {24'd0, bus.rx_data}, 32'h00);
        chk("b2b_overrun_pulses", n_ovr - b_ovr, 32'd2);
        chk("b2b_ferr", n_ferr - b_ferr, 32'd0);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        cycles(1);
        chk("b2b_valid_cleared", {31'd0, bus.rx_valid}, 32'd0);
        sb_check("b2b_data");
        rx_ready = 1'b1;
        cycles(4);

        // Framing error then recovery.
        b_rise = n_rise; b_ferr = n_ferr;
        send_byte(8'h55, 3);
        cycles(4);
        chk("ferr_pulse", n_ferr - b_ferr, 32'd1);
        chk("ferr_no_valid", n_rise - b_rise, 32'd0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 0);
        cycles(4);
        chk("ferr_recover_rise", n_rise - b_rise, 32'd1);
        chk("ferr_recover_no_new_err", n_ferr - b_ferr, 32'd1);
        sb_check("ferr_recover_data");

        // Short glitch in idle.
        b_rise = n_rise; b_ferr = n_ferr; b_busy = n_busy;
        rx_pin = 1'b0;
        cycles(4);
        rx_pin = 1'b1;
        cycles(40);
        chk("glitch_no_valid", n_rise - b_rise, 32'd0);
        chk("glitch_no_ferr", n_ferr - b_ferr, 32'd0);
        chk("glitch_busy_1_to_9", {31'd0, (n_busy - b_busy >= 1) && (n_busy - b_busy <= 9)}, 32'd1);
        chk("glitch_busy_idle", {31'd0, bus.rx_busy}, 32'd0);

        // Reset during data bit 3, line held low through release.
        b_ferr = n_ferr; b_rise = n_rise;
        rx_pin = 1'b0;
        cycles(16 + 48 + 8);
        rst = 1'b1;
        cycles(1);
        chk("rst_mid_busy", {31'd0, bus.rx_busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.rx_valid}, 32'd0);
        cycles(1);
        rst = 1'b0;
        b_busy = n_busy;
        cycles(40);
        chk("rst_low_no_start", n_busy - b_busy, 32'd0);
        rx_pin = 1'b1;
        cycles(20);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 0);
        cycles(4);
        chk("rst_after_rise", n_rise - b_rise, 32'd1);
        chk("rst_no_ferr", n_ferr - b_ferr, 32'd0);
        sb_check("rst_after_data");

        // Accept of a pending byte in the very cycle a new one completes.
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 0);
        cycles(4);
        chk("sim_pending_data", {24'd0, bus.rx_data}, 32'h11);
        b_ovr = n_ovr;
        exp_q.push_back(8'h7E);
        fork
            send_byte(8'h7E, 0);
            begin
                cycles(154);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
            end
        join
        cycles(2);
        chk("sim_valid_kept", {31'd0, bus.rx_valid}, 32'd1);
        chk("sim_new_data", {24'd0, bus.rx_data}, 32'h7E);
        chk("sim_no_overrun", n_ovr - b_ovr, 32'd0);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        cycles(1);
        chk("sim_valid_cleared", {31'd0, bus.rx_valid}, 32'd0);
        sb_check("sim_first_data");
        sb_check("sim_second_data");
        chk("sb_leftover_exp", exp_q.size(), 32'd0);
        chk("sb_leftover_obs", obs_n - rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
